// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and the synchronous instruction memory.
// Response data arrives exactly one cycle after an accepted request.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [31:0]     imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, prefetch FIFO and the IF/ID pipeline register.
// Fetch runs ahead under decode stall until the FIFO plus the in-flight slot fill up.
module fetch_stage #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  fetch_stage_if.master              imem,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       stall_i,
  output logic                       id_valid_o,
  output logic [31:0]                id_instr_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [XLEN-1:0]            id_pc_plus4_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc_q, inflight_pc_q;
  logic            inflight_q;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            id_valid_q;
  logic [31:0]     id_instr_q;
  logic [XLEN-1:0] id_pc_q, id_pc_plus4_q;

  logic            req, grant, push, pop, bypass, wr_en, load, fifo_empty;
  logic [LW:0]     credit;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // No credit for a same-cycle pop, so the FIFO can never be overrun.
  assign credit     = {1'b0, level_q} + (LW + 1)'(inflight_q);
  assign req        = rst_ni && !redirect_i && (credit < (LW + 1)'(DEPTH));
  assign grant      = req && imem.imem_gnt_i;
  assign push       = imem.imem_rvalid_i && inflight_q && !redirect_i;
  assign fifo_empty = (level_q == '0);
  assign load       = !redirect_i && (!stall_i || !id_valid_q);
  assign pop        = load && !fifo_empty;
  // An empty FIFO forwards the arriving response straight into IF/ID.
  assign bypass     = load && fifo_empty && push;
  assign wr_en      = push && !bypass;
  assign head_instr = fifo_empty ? imem.imem_rdata_i : fifo_instr_q[rd_ptr_q];
  assign head_pc    = fifo_empty ? inflight_pc_q : fifo_pc_q[rd_ptr_q];

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = fetch_pc_q;
  assign id_valid_o       = id_valid_q;
  assign id_instr_o       = id_instr_q;
  assign id_pc_o          = id_pc_q;
  assign id_pc_plus4_o    = id_pc_plus4_q;
  assign fifo_level_o     = level_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= grant;
      if (grant) inflight_pc_q <= fetch_pc_q;
      if (redirect_i)  fetch_pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (grant)  fetch_pc_q <= fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (redirect_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        fifo_instr_q[wr_ptr_q] <= imem.imem_rdata_i;
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q               <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop)      level_q <= level_q + LW'(1);
      else if (!wr_en && pop) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP;
      id_pc_q       <= '0;
      id_pc_plus4_q <= XLEN'(4);
    end else if (redirect_i) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP;
    end else if (load) begin
      if (pop || bypass) begin
        id_valid_q    <= 1'b1;
        id_instr_q    <= head_instr;
        id_pc_q       <= head_pc;
        id_pc_plus4_q <= head_pc + XLEN'(4);
      end else begin
        // Bubble: PC fields keep their last value.
        id_valid_q <= 1'b0;
        id_instr_q <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall backpressure, redirect flush,
// random grant, PC wrap and asynchronous reset.
module tb_fetch_stage;

  localparam logic [31:0] MAGIC = 32'hA5A5_0003;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        rst_w_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        gnt = 1'b1;

  logic        id_valid, w_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4, w_instr, w_pc, w_pc_plus4;
  logic [2:0]  level, w_level;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();
  fetch_stage_if #(.XLEN(32)) wbus ();

  fetch_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .imem          (bus),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .stall_i       (stall),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc_plus4),
    .fifo_level_o  (level)
  );

  fetch_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst_ni        (rst_w_n),
    .imem          (wbus),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .stall_i       (1'b0),
    .id_valid_o    (w_valid),
    .id_instr_o    (w_instr),
    .id_pc_o       (w_pc),
    .id_pc_plus4_o (w_pc_plus4),
    .fifo_level_o  (w_level)
  );

  // Memory models: respond one cycle after every accepted request.
  assign bus.imem_gnt_i  = gnt;
  assign wbus.imem_gnt_i = 1'b1;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.imem_rvalid_i <= 1'b0;
      bus.imem_rdata_i  <= '0;
    end else begin
      bus.imem_rvalid_i <= bus.imem_req_o && bus.imem_gnt_i;
      bus.imem_rdata_i  <= bus.imem_addr_o ^ MAGIC;
    end
  end

  always @(posedge clk or negedge rst_w_n) begin
    if (!rst_w_n) begin
      wbus.imem_rvalid_i <= 1'b0;
      wbus.imem_rdata_i  <= '0;
    end else begin
      wbus.imem_rvalid_i <= wbus.imem_req_o;
      wbus.imem_rdata_i  <= wbus.imem_addr_o ^ MAGIC;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    rst_w_n = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.imem_req_o); end
    n_checks++;
    if (bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.imem_addr_o); end
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP) begin
      n_fail++; $display("FAIL reset_id got valid=%b instr=%h want 0/%h", id_valid, id_instr, NOP);
    end
    n_checks++;
    if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || level !== 3'd0) begin
      n_fail++; $display("FAIL reset_pc got pc=%h p4=%h lvl=%0d want 0/4/0", id_pc, id_pc_plus4, level);
    end
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL first_req got req=%b addr=%h want 1/0", bus.imem_req_o, bus.imem_addr_o);
    end
    step();
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL cycle1_valid got %b want 0", id_valid); end
    step();
    exp_pc = 32'h0;
  endtask

  task automatic test_stream(input int n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4
          || id_instr !== (exp_pc ^ MAGIC)) begin
        n_fail++;
        $display("FAIL stream got valid=%b pc=%h p4=%h instr=%h want pc=%h", id_valid, id_pc,
                 id_pc_plus4, id_instr, exp_pc);
      end
      exp_pc += 32'd4;
      step();
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (level !== 3'd3 || id_pc !== exp_pc) begin
      n_fail++; $display("FAIL redir_setup got lvl=%0d pc=%h want 3/%h", level, id_pc, exp_pc);
    end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    stall = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_req got %b want 0", bus.imem_req_o); end
    step();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (level !== 3'd0 || id_valid !== 1'b0 || id_instr !== NOP) begin
      n_fail++; $display("FAIL redir_flush got lvl=%0d valid=%b instr=%h want 0/0/%h", level, id_valid,
                         id_instr, NOP);
    end
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      n_fail++; $display("FAIL redir_fetch got req=%b addr=%h want 1/100", bus.imem_req_o, bus.imem_addr_o);
    end
    step();
    n_checks++;
    if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r2 got valid=%b want 0", id_valid); end
    step();
    exp_pc = 32'h100;
    test_stream(4);
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== held || level > 3'd4) begin
        n_fail++; $display("FAIL stall_hold got valid=%b pc=%h lvl=%0d want 1/%h", id_valid, id_pc, level, held);
      end
      step();
    end
    n_checks++;
    if (level !== 3'd4 || bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== held + 32'd20) begin
      n_fail++; $display("FAIL stall_full got lvl=%0d req=%b addr=%h want 4/0/%h", level,
                         bus.imem_req_o, bus.imem_addr_o, held + 32'd20);
    end
    stall = 1'b0;
    step();
    exp_pc = held + 32'd4;
    test_stream(8);
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || level !== 3'd0) begin
      n_fail++; $display("FAIL rs_flush got valid=%b instr=%h lvl=%0d want 0/%h/0", id_valid, id_instr, level, NOP);
    end
    n_checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
      n_fail++; $display("FAIL rs_fetch got req=%b addr=%h want 1/200", bus.imem_req_o, bus.imem_addr_o);
    end
    step();
    step();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      n_fail++; $display("FAIL rs_first got valid=%b pc=%h want 1/200", id_valid, id_pc);
    end
    stall = 1'b0;
    step();
    exp_pc = 32'h204;
    test_stream(3);
  endtask

  task automatic test_random_gnt();
    logic        p_req, p_gnt;
    logic [31:0] p_addr;
    int          seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (id_valid === 1'b1) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== (exp_pc ^ MAGIC)) begin
          n_fail++; $display("FAIL rnd_seq got pc=%h instr=%h want pc=%h", id_pc, id_instr, exp_pc);
        end
        exp_pc += 32'd4;
        seen++;
      end
      gnt = 1'($urandom_range(0, 1));
      #1;
      p_req = bus.imem_req_o;
      p_gnt = gnt;
      p_addr = bus.imem_addr_o;
      step();
      if (p_req && !p_gnt) begin
        n_checks++;
        if (bus.imem_addr_o !== p_addr) begin
          n_fail++; $display("FAIL rnd_hold got addr=%h want %h", bus.imem_addr_o, p_addr);
        end
      end
    end
    gnt = 1'b1;
    n_checks++;
    if (seen < 10) begin n_fail++; $display("FAIL rnd_progress got %0d instrs want >=10", seen); end
  endtask

  task automatic test_wrap_reset();
    rst_w_n = 1'b1;
    #1;
    n_checks++;
    if (wbus.imem_req_o !== 1'b1 || wbus.imem_addr_o !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL wrap_req got req=%b addr=%h want 1/fffffff8", wbus.imem_req_o, wbus.imem_addr_o);
    end
    step();
    step();
    n_checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8 || w_pc_plus4 !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap0 got valid=%b pc=%h p4=%h want 1/fffffff8/fffffffc", w_valid, w_pc, w_pc_plus4);
    end
    step();
    n_checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap1 got valid=%b pc=%h p4=%h want 1/fffffffc/0", w_valid, w_pc, w_pc_plus4);
    end
    step();
    n_checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_instr !== MAGIC) begin
      n_fail++; $display("FAIL wrap2 got valid=%b pc=%h instr=%h want 1/0/%h", w_valid, w_pc, w_instr, MAGIC);
    end
    step();
    rst_w_n = 1'b0;
    #1;
    n_checks++;
    if (w_valid !== 1'b0 || w_instr !== NOP || w_pc !== 32'h0 || w_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL async_id got valid=%b instr=%h pc=%h p4=%h want 0/%h/0/4", w_valid, w_instr,
                         w_pc, w_pc_plus4, NOP);
    end
    n_checks++;
    if (wbus.imem_req_o !== 1'b0 || wbus.imem_addr_o !== 32'hFFFF_FFF8 || w_level !== 3'd0) begin
      n_fail++; $display("FAIL async_fetch got req=%b addr=%h lvl=%0d want 0/fffffff8/0", wbus.imem_req_o,
                         wbus.imem_addr_o, w_level);
    end
  endtask

  initial begin
    test_reset();
    test_stream(6);
    test_redirect();
    test_stall();
    test_redirect_stall();
    test_random_gnt();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
